// File: rtl/pc_call_stack_if.sv
// Control/bus bundle between the sequencer and the program counter block.
// The sequencer side (master) drives requests and the jump/call target.
// The PC side (slave) returns the current PC, stack occupancy and error flags.
interface pc_call_stack_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              pc_en;
  logic              jmp;
  logic              jz;
  logic              zero_flag;
  logic              call;
  logic              ret;
  logic              clr_err;
  logic [ADDR_W-1:0] bus_in;
  logic [ADDR_W-1:0] bus_out;
  logic [ADDR_W-1:0] dis_out;
  logic [SP_W-1:0]   sp_out;
  logic              stk_full;
  logic              stk_empty;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output pc_en, jmp, jz, zero_flag, call, ret, clr_err, bus_in,
    input  bus_out, dis_out, sp_out, stk_full, stk_empty, ovf_err, unf_err
  );

  modport slave (
    input  pc_en, jmp, jz, zero_flag, call, ret, clr_err, bus_in,
    output bus_out, dis_out, sp_out, stk_full, stk_empty, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_call_stack.sv
// Program counter with increment, unconditional/conditional jump and a
// hardware return-address stack. One action per clock edge, chosen by
// priority ret > call > jmp > jz > pc_en. Every output comes straight from a
// register, so there is no combinational path from any input to any output.
module pc_call_stack #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input logic            clk,
  input logic            reset,
  pc_call_stack_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push;
  logic [ADDR_W-1:0] pc_inc;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  // A push only happens while sp < STACK_DEPTH and a pop only while sp > 0,
  // so both truncated indices always land inside the stack array.
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  // Next-state selection: the single highest-priority request wins, the rest are dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pc_d  = pc_q;
    sp_d  = sp_q;
    push  = 1'b0;
    // Clear happens first; an error raised below on the same edge overrides it.
    ovf_d = ovf_q & ~bus.clr_err;
    unf_d = unf_q & ~bus.clr_err;

    if (bus.ret) begin
      if (sp_q != '0) begin
        pc_d = stack_q[pop_idx];
        sp_d = sp_q - SP_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (bus.call) begin
      if (sp_q != SP_W'(STACK_DEPTH)) begin
        push = 1'b1;
        sp_d = sp_q + SP_W'(1);
        pc_d = bus.bus_in;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (bus.jmp) begin
      pc_d = bus.bus_in;
    end else if (bus.jz) begin
      pc_d = bus.zero_flag ? bus.bus_in : pc_inc;
    end else if (bus.pc_en) begin
      pc_d = pc_inc;
    end
  end

  // PC, stack pointer and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Return-address storage; entries above sp are left untouched on pop.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: this small register-file stack is reset on purpose so every entry is a known 0 after reset.
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign bus.bus_out   = pc_q;
  assign bus.dis_out   = pc_q;
  assign bus.sp_out    = sp_q;
  assign bus.stk_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign bus.stk_empty = (sp_q == '0);
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;
endmodule
